// File: rtl/rgmii_idelay_cal_pkg.sv
// Shared widths, FSM encoding and centre arithmetic for the RGMII RX IDELAY calibrator.
// Purely declarative: no logic, no latency.
package rgmii_cal_pkg;

    localparam int TAP_W            = 5;
    localparam int NUM_TAPS         = 32;
    localparam int LEN_W            = 6;
    localparam int STEP_WAIT_CYCLES = 2;

    localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(NUM_TAPS - 1);

    typedef enum logic [3:0] {
        IDLE,
        HOME,
        STEP_WAIT,
        CLEAR,
        SETTLE,
        DWELL,
        EVAL,
        CENTER_CALC,
        CENTER_STEP,
        CHECK,
        FIN
    } cal_state_t;

    // Floor centre of a window; lower-middle tap for even lengths.
    function automatic logic [TAP_W-1:0] center_of(input logic [TAP_W-1:0] start,
                                                   input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] half;
        half = (len - LEN_W'(1)) >> 1;
        return start + half[TAP_W-1:0];
    endfunction

endpackage

// File: rtl/rgmii_idelay_cal_if.sv
// Register-side status and IDELAY/jumbo-test side buses of the calibrator.
// master = calibrator, slave = register block plus IDELAY/error-flag owners.
interface rgmii_idelay_cal_if
    import rgmii_cal_pkg::*;
#(
    parameter int LANES = 5
);
    logic                     start;
    logic                     busy;
    logic                     done;
    logic [LANES-1:0]         lane_fail;
    logic [LANES*TAP_W-1:0]   lane_center;
    logic [LANES*LEN_W-1:0]   lane_width;
    logic [LANES-1:0]         dly_inc;
    logic [LANES*TAP_W-1:0]   dly_value;
    logic [LANES-1:0]         err_clear;
    logic [LANES-1:0]         lane_err;

    modport master (
        input  start, dly_value, lane_err,
        output busy, done, lane_fail, lane_center, lane_width, dly_inc, err_clear
    );

    modport slave (
        output start, dly_value, lane_err,
        input  busy, done, lane_fail, lane_center, lane_width, dly_inc, err_clear
    );

endinterface

// File: rtl/rgmii_idelay_cal_window_track.sv
// Tracks the current passing run and the widest run seen during a tap sweep.
// Updates one cycle after sample_en; ties keep the earlier window.
module idelay_window_track
    import rgmii_cal_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             sample_en,
    input  logic             pass,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] best_start,
    output logic [LEN_W-1:0] best_len
);

    logic [TAP_W-1:0] run_start;
    logic [LEN_W-1:0] run_len;
    logic [TAP_W-1:0] run_start_new;
    logic [LEN_W-1:0] run_len_new;

    assign run_start_new = (run_len == '0) ? tap : run_start;
    assign run_len_new   = run_len + LEN_W'(1);

    always_ff @(posedge clk) begin
        if (rst || init) begin
            run_start  <= '0;
            run_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (sample_en) begin
            if (pass) begin
                run_start <= run_start_new;
                run_len   <= run_len_new;
                if (run_len_new > best_len) begin
                    best_start <= run_start_new;
                    best_len   <= run_len_new;
                end
            end else begin
                run_len <= '0;
            end
        end
    end

endmodule

// File: rtl/rgmii_idelay_cal.sv
// Sequential per-lane IDELAY sweep: home, scan 32 taps against the jumbo-test flag, park at window centre.
// Runs for milliseconds per lane; start is ignored while busy, reset aborts at once.
module rgmii_idelay_cal
    import rgmii_cal_pkg::*;
#(
    parameter int LANES         = 5,
    parameter int SETTLE_CYCLES = 64,
    parameter int DWELL_CYCLES  = 125000,
    parameter int MIN_WINDOW    = 4,
    parameter int DEFAULT_TAP   = 25
)(
    input  logic                clk,
    input  logic                rst,
    rgmii_idelay_cal_if.master  bus
);

    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_MAX = (DWELL_CYCLES > SETTLE_CYCLES)
                           ? ((DWELL_CYCLES > STEP_WAIT_CYCLES) ? DWELL_CYCLES : STEP_WAIT_CYCLES)
                           : ((SETTLE_CYCLES > STEP_WAIT_CYCLES) ? SETTLE_CYCLES : STEP_WAIT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    cal_state_t               state, state_nxt, ret_state, ret_nxt;
    logic [LANE_W-1:0]        lane, lane_nxt;
    logic [TAP_W-1:0]         tap, tap_nxt, target, target_nxt, step_cnt, step_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic                     trk_init, trk_sample, fail_set, result_latch, result_clr;
    logic [TAP_W-1:0]         best_start, cur_value;
    logic [LEN_W-1:0]         best_len;
    logic                     cur_err;
    logic [LANES-1:0]         lane_sel;
    logic [LANES-1:0]         fail_q;
    logic [LANES*TAP_W-1:0]   center_q;
    logic [LANES*LEN_W-1:0]   width_q;

    assign cur_value = bus.dly_value[lane*TAP_W +: TAP_W];
    assign cur_err   = bus.lane_err[lane];
    assign lane_sel  = LANES'(1) << lane;

    // The inc pulse occupies the first STEP_WAIT cycle; STEP_WAIT_CYCLES idle cycles follow it.
    assign bus.dly_inc     = (state == STEP_WAIT && cnt == '0) ? lane_sel : '0;
    assign bus.err_clear   = (state == CLEAR) ? lane_sel : '0;
    assign bus.busy        = (state != IDLE) && (state != FIN);
    assign bus.done        = (state == FIN);
    assign bus.lane_fail   = fail_q;
    assign bus.lane_center = center_q;
    assign bus.lane_width  = width_q;

    idelay_window_track u_track (
        .clk        (clk),
        .rst        (rst),
        .init       (trk_init),
        .sample_en  (trk_sample),
        .pass       (~cur_err),
        .tap        (tap),
        .best_start (best_start),
        .best_len   (best_len)
    );

    always_comb begin
        state_nxt    = state;
        ret_nxt      = ret_state;
        lane_nxt     = lane;
        tap_nxt      = tap;
        target_nxt   = target;
        step_nxt     = step_cnt;
        cnt_nxt      = cnt;
        trk_init     = 1'b0;
        trk_sample   = 1'b0;
        fail_set     = 1'b0;
        result_latch = 1'b0;
        result_clr   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt  = HOME;
                    lane_nxt   = '0;
                    result_clr = 1'b1;
                end
            end
            HOME: begin
                if (cur_value != '0) begin
                    state_nxt = STEP_WAIT;
                    ret_nxt   = HOME;
                    cnt_nxt   = '0;
                end else begin
                    tap_nxt   = '0;
                    trk_init  = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            STEP_WAIT: begin
                if (cnt == CNT_W'(STEP_WAIT_CYCLES)) begin
                    state_nxt = ret_state;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            CLEAR: begin
                state_nxt = SETTLE;
                cnt_nxt   = '0;
            end
            SETTLE: begin
                if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_nxt = DWELL;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DWELL: begin
                if (cnt == CNT_W'(DWELL_CYCLES - 1)) begin
                    state_nxt = EVAL;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            EVAL: begin
                trk_sample = 1'b1;
                if (tap == TAP_MAX) begin
                    state_nxt = CENTER_CALC;
                end else begin
                    tap_nxt   = tap + TAP_W'(1);
                    ret_nxt   = CLEAR;
                    state_nxt = STEP_WAIT;
                    cnt_nxt   = '0;
                end
            end
            CENTER_CALC: begin
                if (best_len < LEN_W'(MIN_WINDOW)) begin
                    target_nxt = TAP_W'(DEFAULT_TAP);
                    fail_set   = 1'b1;
                end else begin
                    target_nxt = center_of(best_start, best_len);
                end
                // Tap sits at 31 after the sweep; this inc wraps it to 0.
                step_nxt  = '0;
                ret_nxt   = CENTER_STEP;
                state_nxt = STEP_WAIT;
                cnt_nxt   = '0;
            end
            CENTER_STEP: begin
                if (step_cnt != target) begin
                    step_nxt  = step_cnt + TAP_W'(1);
                    ret_nxt   = CENTER_STEP;
                    state_nxt = STEP_WAIT;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                result_latch = 1'b1;
                if (cur_value != target) fail_set = 1'b1;
                if (lane == LANE_W'(LANES - 1)) begin
                    state_nxt = FIN;
                end else begin
                    lane_nxt  = lane + LANE_W'(1);
                    state_nxt = HOME;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ret_state <= IDLE;
            lane      <= '0;
            tap       <= '0;
            target    <= '0;
            step_cnt  <= '0;
            cnt       <= '0;
            fail_q    <= '0;
            center_q  <= '0;
            width_q   <= '0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            lane      <= lane_nxt;
            tap       <= tap_nxt;
            target    <= target_nxt;
            step_cnt  <= step_nxt;
            cnt       <= cnt_nxt;
            if (result_clr) begin
                fail_q   <= '0;
                center_q <= '0;
                width_q  <= '0;
            end
            if (fail_set) fail_q[lane] <= 1'b1;
            if (result_latch) begin
                center_q[lane*TAP_W +: TAP_W] <= cur_value;
                width_q[lane*LEN_W +: LEN_W]  <= best_len;
            end
        end
    end

endmodule

// File: tb/tb_rgmii_idelay_cal.sv
// Directed bench: behavioural IDELAY counters and sticky error flags driven from per-lane pass maps.
module tb_rgmii_idelay_cal;
    import rgmii_cal_pkg::*;

    localparam int LANES  = 5;
    localparam int SETTLE = 4;
    localparam int DWELL  = 16;
    localparam int MINW   = 2;
    localparam int DEFTAP = 25;

    logic clk = 1'b0;
    logic rst;
    always #4 clk = ~clk;

    rgmii_idelay_cal_if #(.LANES(LANES)) bus ();

    rgmii_idelay_cal #(
        .LANES(LANES), .SETTLE_CYCLES(SETTLE), .DWELL_CYCLES(DWELL),
        .MIN_WINDOW(MINW), .DEFAULT_TAP(DEFTAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [4:0]       tap_m      [LANES];
    logic [4:0]       preset_val [LANES];
    logic [31:0]      pass_map   [LANES];
    logic [LANES-1:0] err_q;
    logic             preset_en;
    logic             cnt_rst;
    int               inc_cnt [LANES];
    int               clr_cnt [LANES];
    int               done_cnt;
    int               exp_center [LANES];
    int               exp_width  [LANES];
    int               exp_fail   [LANES];
    int               checks = 0;
    int               errors = 0;

    for (genvar g = 0; g < LANES; g++) begin : g_val
        assign bus.dly_value[g*5 +: 5] = tap_m[g];
    end
    assign bus.lane_err = err_q;

    always @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (preset_en) tap_m[i] <= preset_val[i];
            else if (bus.dly_inc[i]) tap_m[i] <= tap_m[i] + 5'd1;
            if (preset_en || bus.err_clear[i]) err_q[i] <= 1'b0;
            else if (!pass_map[i][tap_m[i]]) err_q[i] <= 1'b1;
            if (cnt_rst) begin
                inc_cnt[i] <= 0;
                clr_cnt[i] <= 0;
            end else begin
                if (bus.dly_inc[i])   inc_cnt[i] <= inc_cnt[i] + 1;
                if (bus.err_clear[i]) clr_cnt[i] <= clr_cnt[i] + 1;
            end
        end
        if (cnt_rst) done_cnt <= 0;
        else if (bus.done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        @(negedge clk) cnt_rst = 1'b1;
        @(negedge clk) cnt_rst = 1'b0;
    endtask

    task automatic start_pulse(input string tag);
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        check({tag, " busy_after_start"}, bus.busy, 1);
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while (!bus.done && c < 20000) begin
            @(negedge clk);
            c++;
        end
        check({tag, " done_seen"}, bus.done, 1);
        check({tag, " busy_low_in_fin"}, bus.busy, 0);
        @(negedge clk);
        check({tag, " done_one_cycle"}, bus.done, 0);
        check({tag, " done_count"}, done_cnt, 1);
    endtask

    task automatic check_results(input string tag);
        for (int i = 0; i < LANES; i++) begin
            check($sformatf("%s center%0d", tag, i), bus.lane_center[i*5 +: 5], exp_center[i]);
            check($sformatf("%s width%0d", tag, i), bus.lane_width[i*6 +: 6], exp_width[i]);
            check($sformatf("%s fail%0d", tag, i), bus.lane_fail[i], exp_fail[i]);
            check($sformatf("%s tap%0d", tag, i), tap_m[i], exp_center[i]);
        end
    endtask

    initial begin
        int inc_sum, clr_sum, c;
        rst       = 1'b1;
        bus.start = 1'b0;
        preset_en = 1'b1;
        cnt_rst   = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            preset_val[i] = 5'd0;
            pass_map[i]   = 32'h000F_FC00;   // taps 10..19
        end
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        preset_en = 1'b0;
        cnt_rst   = 1'b0;
        @(negedge clk);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset lane_fail", bus.lane_fail, 0);
        check("reset lane_center", bus.lane_center, 0);
        check("reset lane_width", bus.lane_width, 0);
        check("reset dly_inc", bus.dly_inc, 0);
        check("reset err_clear", bus.err_clear, 0);

        // Run A: homed lanes, window 10..19 -> centre 10+(9>>1)=14.
        for (int i = 0; i < LANES; i++) begin
            exp_center[i] = 14; exp_width[i] = 10; exp_fail[i] = 0;
        end
        start_pulse("A");
        wait_done("A");
        check_results("A");
        for (int i = 0; i < LANES; i++) begin
            // 31 sweep incs + 1 wrap + 14 to centre
            check($sformatf("A incs%0d", i), inc_cnt[i], 46);
            check($sformatf("A clears%0d", i), clr_cnt[i], 32);
        end

        // Run B: lane1 two 3-wide windows, lane2 starts at 7 passing 20..31, lane4 all fail.
        pass_map[1] = 32'h0070_0038;
        pass_map[2] = 32'hFFF0_0000;
        pass_map[4] = 32'h0000_0000;
        @(negedge clk);
        preset_val[0] = 5'd14; preset_val[1] = 5'd14; preset_val[2] = 5'd7;
        preset_val[3] = 5'd14; preset_val[4] = 5'd14;
        preset_en = 1'b1;
        @(negedge clk) preset_en = 1'b0;
        clear_counts();
        exp_center[1] = 4;  exp_width[1] = 3;  exp_fail[1] = 0;
        exp_center[2] = 25; exp_width[2] = 12; exp_fail[2] = 0;
        exp_center[4] = 25; exp_width[4] = 0;  exp_fail[4] = 1;
        start_pulse("B");
        wait_done("B");
        check_results("B");
        check("B incs0", inc_cnt[0], 18 + 31 + 1 + 14);
        check("B incs2", inc_cnt[2], 25 + 31 + 1 + 25);
        check("B incs4", inc_cnt[4], 18 + 31 + 1 + 25);

        // Run C: reset in the middle of lane 3's dwell.
        clear_counts();
        start_pulse("C");
        c = 0;
        while (clr_cnt[3] == 0 && c < 20000) begin
            @(negedge clk);
            c++;
        end
        check("C reached lane3", clr_cnt[3] > 0, 1);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("C abort busy", bus.busy, 0);
        check("C abort done", bus.done, 0);
        check("C abort lane_center", bus.lane_center, 0);
        check("C abort lane_width", bus.lane_width, 0);
        inc_sum = 0;
        clr_sum = 0;
        for (int i = 0; i < LANES; i++) begin
            inc_sum += inc_cnt[i];
            clr_sum += clr_cnt[i];
        end
        repeat (200) @(negedge clk);
        for (int i = 0; i < LANES; i++) begin
            inc_sum -= inc_cnt[i];
            clr_sum -= clr_cnt[i];
        end
        check("C no incs after abort", inc_sum, 0);
        check("C no clears after abort", clr_sum, 0);
        check("C still idle", bus.busy, 0);

        // Run D: fresh calibration with a stray start mid-run.
        clear_counts();
        start_pulse("D");
        repeat (300) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        check("D busy after stray start", bus.busy, 1);
        wait_done("D");
        check_results("D");
        check("D clears0", clr_cnt[0], 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
